// File: rtl/fft_pkg.sv
// Shared types and widths for the FFT frame sink.
// Holds the FSM state enum and default sizes.
package fft_pkg;

  localparam int DW_DEF       = 8;
  localparam int LEN_LOG2_DEF = 9;
  localparam int EXP_W        = 6;
  localparam int ERR_W        = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/fft_frame_sink_if.sv
// Streaming handshake from the FFT core into the frame sink.
// The master drives beats and the slave returns back-pressure.
interface fft_frame_sink_if #(
  parameter int DW = fft_pkg::DW_DEF
);

  logic                      src_valid;
  logic                      src_sop;
  logic                      src_eop;
  logic [DW-1:0]             src_real;
  logic [DW-1:0]             src_imag;
  logic [fft_pkg::EXP_W-1:0] src_exp;
  logic                      src_ready;

  modport master (
    output src_valid, src_sop, src_eop,
    output src_real, src_imag, src_exp,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_sop, src_eop,
    input  src_real, src_imag, src_exp,
    output src_ready
  );

endinterface

// File: rtl/fft_bank_ram.sv
// One ping-pong bank: simple dual-port RAM, registered read.
// Contents are not reset; only the read register is.
module fft_bank_ram #(
  parameter int AW = 9,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/fft_frame_sink.sv
// Collects FFT output frames into two ping-pong banks for a reader.
// Define FFT_FRAME_SINK_MAG_EN to store |re|+|im| instead of {re,im}.
module fft_frame_sink
  import fft_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int LEN_LOG2 = LEN_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset,
  fft_frame_sink_if.slave     src,
  input  logic [LEN_LOG2-1:0] rd_addr,
  input  logic                rd_req,
  input  logic                rd_release,
  output logic [2*DW-1:0]     rd_data,
  output logic                rd_valid,
  output logic                frame_ready,
  output logic [EXP_W-1:0]    frame_exp,
  output logic                frame_done,
  output logic                frame_err,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [LEN_LOG2-1:0] bin_cnt
);

  localparam int W = 2 * DW;
  localparam logic [LEN_LOG2-1:0] LAST = '1;

  state_t state_q, state_d;

  logic [LEN_LOG2-1:0] bin_q, bin_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, rd_bank_q, rd_sel_q;
  logic [EXP_W-1:0]    exp_cur_q;
  logic [EXP_W-1:0]    exp_q [2];
  logic                done_q, ferr_q, rv_q;

  logic accept, rel, rd_en;
  logic ev_start, ev_data, ev_done, ev_err;
  logic                we;
  logic [LEN_LOG2-1:0] waddr;
  logic [W-1:0]        wdata;
  logic [W-1:0]        q0, q1;

  assign src.src_ready = !full_q[wr_bank_q];
  assign accept        = src.src_valid & src.src_ready;
  assign frame_ready   = full_q[rd_bank_q];
  assign rel           = rd_release & frame_ready;
  assign rd_en         = rd_req & frame_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // sop always wins; a sop inside a frame restarts it and counts as an error
  always_comb begin
    state_d  = state_q;
    ev_start = 1'b0;
    ev_data  = 1'b0;
    ev_done  = 1'b0;
    ev_err   = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (src.src_sop) begin
            ev_start = 1'b1;
            state_d  = S_COLLECT;
          end else begin
            ev_err  = 1'b1;
            state_d = S_FLUSH;
          end
        end
        S_COLLECT: begin
          if (src.src_sop) begin
            ev_err   = 1'b1;
            ev_start = 1'b1;
          end else if (bin_q == LAST) begin
            ev_data = 1'b1;
            if (src.src_eop) begin
              ev_done = 1'b1;
              state_d = S_IDLE;
            end else begin
              ev_err  = 1'b1;
              state_d = S_FLUSH;
            end
          end else if (src.src_eop) begin
            ev_err  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ev_data = 1'b1;
          end
        end
        S_FLUSH: begin
          if (src.src_sop) begin
            ev_start = 1'b1;
            state_d  = S_COLLECT;
          end else if (src.src_eop) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    we    = ev_start | ev_data;
    waddr = ev_start ? '0 : bin_q;
    bin_d = bin_q;
    if (ev_start)            bin_d = LEN_LOG2'(1);
    else if (ev_done|ev_err) bin_d = '0;
    else if (ev_data)        bin_d = bin_q + LEN_LOG2'(1);
    err_d = err_q;
    if (ev_err && err_q != '1) err_d = err_q + ERR_W'(1);
    full_d = full_q;
    if (rel)     full_d[rd_bank_q] = 1'b0;
    if (ev_done) full_d[wr_bank_q] = 1'b1;
  end

`ifdef FFT_FRAME_SINK_MAG_EN
  logic [DW:0] abs_re, abs_im, mag;
  assign abs_re = src.src_real[DW-1]
                ? {1'b0, ~src.src_real} + (DW+1)'(1)
                : {1'b0, src.src_real};
  assign abs_im = src.src_imag[DW-1]
                ? {1'b0, ~src.src_imag} + (DW+1)'(1)
                : {1'b0, src.src_imag};
  assign mag    = abs_re + abs_im;
  assign wdata  = {{(DW-1){1'b0}}, mag};
`else
  assign wdata  = {src.src_real, src.src_imag};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q     <= '0;
      err_q     <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      exp_cur_q <= '0;
      exp_q[0]  <= '0;
      exp_q[1]  <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      err_q  <= err_d;
      full_q <= full_d;
      done_q <= ev_done;
      ferr_q <= ev_err;
      rv_q   <= rd_en;
      if (ev_start) exp_cur_q <= src.src_exp;
      if (ev_done) begin
        exp_q[wr_bank_q] <= exp_cur_q;
        wr_bank_q        <= !wr_bank_q;
      end
      if (rel)   rd_bank_q <= !rd_bank_q;
      if (rd_en) rd_sel_q  <= rd_bank_q;
    end
  end

  fft_bank_ram #(.AW(LEN_LOG2), .W(W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we & !wr_bank_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rd_en & !rd_bank_q),
    .raddr_i (rd_addr),
    .rdata_o (q0)
  );

  fft_bank_ram #(.AW(LEN_LOG2), .W(W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we & wr_bank_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rd_en & rd_bank_q),
    .raddr_i (rd_addr),
    .rdata_o (q1)
  );

  assign rd_data    = rd_sel_q ? q1 : q0;
  assign rd_valid   = rv_q;
  assign frame_exp  = frame_ready ? exp_q[rd_bank_q] : '0;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;
  assign err_cnt    = err_q;
  assign bin_cnt    = bin_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Randomized bench for fft_frame_sink against a frame-queue model.
// Directed scenarios cover back-pressure, framing errors and reset.
module tb_fft_frame_sink;

  localparam int DW = 8;
  localparam int LL = 9;
  localparam int N  = 1 << LL;

  typedef logic [2*DW-1:0] word_t;

  localparam int P_WAIT = 0;
  localparam int P_IN   = 1;
  localparam int P_SKIP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_frame_sink_if #(.DW(DW)) src ();

  logic [LL-1:0]   rd_addr = '0;
  logic            rd_req = 1'b0;
  logic            rd_release = 1'b0;
  logic [2*DW-1:0] rd_data;
  logic            rd_valid, frame_ready;
  logic [5:0]      frame_exp;
  logic            frame_done, frame_err;
  logic [7:0]      err_cnt;
  logic [LL-1:0]   bin_cnt;

  fft_frame_sink #(.DW(DW), .LEN_LOG2(LL)) dut (
    .clk         (clk),
    .reset       (reset),
    .src         (src),
    .rd_addr     (rd_addr),
    .rd_req      (rd_req),
    .rd_release  (rd_release),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready),
    .frame_exp   (frame_exp),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .bin_cnt     (bin_cnt)
  );

  // reference model: completed frames queued oldest-first
  word_t      fq[$];
  logic [5:0] eq[$];
  word_t      cur [N];
  logic [5:0] cur_exp;
  int         m_phase, m_n, m_err;
  logic       m_rv, m_acc;
  word_t      m_rd;

  int nvec = 0;
  int nbad = 0;
  int dut_done = 0;
  bit poke_mag = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t mkword(logic [DW-1:0] re, logic [DW-1:0] im);
`ifdef FFT_FRAME_SINK_MAG_EN
    int a, b;
    a = $signed(re);
    b = $signed(im);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return word_t'(a + b);
`else
    return {re, im};
`endif
  endfunction

  task automatic model_clear();
    fq.delete();
    eq.delete();
    m_phase = P_WAIT;
    m_n     = 0;
    m_err   = 0;
    m_rv    = 1'b0;
    m_rd    = '0;
    m_acc   = 1'b0;
  endtask

  // one clock: check idle-side outputs, advance model, check edge results
  task automatic step();
    int    cnt;
    bit    acc, rel, comp, er, rv;
    word_t w, rdw;
    cnt = eq.size();
    check("src_ready", src.src_ready, cnt < 2);
    check("frame_ready", frame_ready, cnt > 0);
    check("frame_exp", frame_exp, (cnt > 0) ? eq[0] : 6'd0);
    acc  = src.src_valid && (cnt < 2);
    rv   = rd_req && (cnt > 0);
    rel  = rd_release && (cnt > 0);
    comp = 1'b0;
    er   = 1'b0;
    rdw  = '0;
    if (rv) rdw = fq[rd_addr];
    if (acc) begin
      w = mkword(src.src_real, src.src_imag);
      if (src.src_sop) begin
        if (m_phase == P_IN) er = 1'b1;
        cur[0]  = w;
        cur_exp = src.src_exp;
        m_n     = 1;
        m_phase = P_IN;
      end else if (m_phase == P_WAIT) begin
        er      = 1'b1;
        m_phase = P_SKIP;
      end else if (m_phase == P_SKIP) begin
        if (src.src_eop) m_phase = P_WAIT;
      end else if (m_n == N - 1) begin
        if (src.src_eop) begin
          cur[N-1] = w;
          comp     = 1'b1;
          m_phase  = P_WAIT;
        end else begin
          er      = 1'b1;
          m_phase = P_SKIP;
        end
        m_n = 0;
      end else if (src.src_eop) begin
        er      = 1'b1;
        m_phase = P_WAIT;
        m_n     = 0;
      end else begin
        cur[m_n] = w;
        m_n++;
      end
    end
    @(posedge clk);
    if (rel) begin
      for (int i = 0; i < N; i++) void'(fq.pop_front());
      void'(eq.pop_front());
    end
    if (comp) begin
      for (int i = 0; i < N; i++) fq.push_back(cur[i]);
      eq.push_back(cur_exp);
    end
    if (er && m_err < 255) m_err++;
    m_rv  = rv;
    if (rv) m_rd = rdw;
    m_acc = acc;
    @(negedge clk);
    check("frame_done", frame_done, comp);
    check("frame_err", frame_err, er);
    check("err_cnt", err_cnt, m_err);
    check("bin_cnt", bin_cnt, m_n);
    check("rd_valid", rd_valid, m_rv);
    check("rd_data", rd_data, m_rd);
    if (frame_done) dut_done++;
  endtask

  task automatic rand_rd(int rel_pm);
    rd_req     = ($urandom_range(0, 3) == 0);
    rd_addr    = LL'($urandom);
    rd_release = ($urandom_range(0, 999) < rel_pm);
  endtask

  task automatic idle();
    src.src_valid = 1'b0;
    rd_req        = 1'b0;
    rd_release    = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    src.src_valid = 1'b0;
    src.src_sop   = 1'b0;
    src.src_eop   = 1'b0;
    rd_req        = 1'b0;
    rd_release    = 1'b0;
    #1;
    check("rst_src_ready", src.src_ready, 1);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_exp", frame_exp, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bin_cnt", bin_cnt, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // n beats: sop at 0 and at sop_b, eop at eop_at; stalled beats are re-presented
  task automatic send(int n, int sop_b, int eop_at, logic [5:0] ex,
                      bit rnd, int rel_pm);
    logic [7:0]    b;
    logic [DW-1:0] re, im;
    int            tries;
    for (int i = 0; i < n; i++) begin
      b  = i[7:0];
      re = rnd ? DW'($urandom) : b;
      im = rnd ? DW'($urandom) : ~b;
      if (poke_mag && i == 7) begin
        re = 8'h80;
        im = 8'h7F;
      end
      if (rnd && $urandom_range(0, 7) == 0) begin
        src.src_valid = 1'b0;
        src.src_sop   = 1'($urandom);
        src.src_eop   = 1'($urandom);
        rand_rd(rel_pm);
        step();
      end
      tries = 0;
      do begin
        src.src_valid = 1'b1;
        src.src_sop   = (i == 0) || (i == sop_b);
        src.src_eop   = (i == eop_at);
        src.src_real  = re;
        src.src_imag  = im;
        src.src_exp   = ex;
        rand_rd(rel_pm);
        step();
        tries++;
      end while (!m_acc && tries < 4000);
      if (!m_acc) begin
        check("stall_bound", 0, 1);
        break;
      end
    end
    idle();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (eq.size() > 0 && g < 8) begin
      src.src_valid = 1'b0;
      rd_req        = 1'b0;
      rd_release    = 1'b1;
      step();
      g++;
    end
    rd_release = 1'b0;
  endtask

  initial begin
    int d0;
    src.src_valid = 1'b0;
    src.src_sop   = 1'b0;
    src.src_eop   = 1'b0;
    src.src_real  = '0;
    src.src_imag  = '0;
    src.src_exp   = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // single frame with the bin pattern, exponent -3
    send(N, -1, N - 1, 6'h3D, 1'b0, 0);
    check("one_done", dut_done, 1);
    check("ready_after_frame", frame_ready, 1);
    check("exp_after_frame", frame_exp, 6'h3D);
    rd_req  = 1'b1;
    rd_addr = 9'd5;
    step();
    rd_req  = 1'b0;
    check("rd5_valid", rd_valid, 1);
`ifdef FFT_FRAME_SINK_MAG_EN
    check("rd5_data", rd_data, 16'h000B);
`else
    check("rd5_data", rd_data, 16'h05FA);
`endif

    // second frame fills both banks, third stalls until a release
    send(N, -1, N - 1, 6'h11, 1'b1, 0);
    check("full_ready_low", src.src_ready, 0);
    for (int k = 0; k < 5; k++) begin
      src.src_valid = 1'b1;
      src.src_sop   = 1'b1;
      src.src_eop   = 1'b0;
      rd_req        = 1'b0;
      rd_release    = 1'b0;
      step();
    end
    check("stall_bin", bin_cnt, 0);
    check("stall_done_cnt", dut_done, 2);
    src.src_valid = 1'b0;
    rd_release    = 1'b1;
    step();
    rd_release    = 1'b0;
    check("ready_after_rel", src.src_ready, 1);
    send(N, -1, N - 1, 6'h22, 1'b1, 0);
    check("third_done", dut_done, 3);
    drain();

    // early eop at bin 100
    do_reset();
    d0 = dut_done;
    send(101, -1, 100, 6'h05, 1'b1, 0);
    check("early_eop_err", err_cnt, 1);
    check("early_eop_nodone", dut_done, d0);
    send(N, -1, N - 1, 6'h06, 1'b1, 0);
    check("good_after_err", dut_done, d0 + 1);
    drain();

    // sop at bin 300 restarts the frame
    do_reset();
    d0 = dut_done;
    send(300 + N, 300, 300 + N - 1, 6'h07, 1'b1, 0);
    check("restart_err", err_cnt, 1);
    check("restart_done", dut_done, d0 + 1);
    drain();

    // reset mid-frame with one frame buffered
    do_reset();
    send(N, -1, N - 1, 6'h08, 1'b1, 0);
    send(200, -1, -1, 6'h09, 1'b1, 0);
    check("pre_rst_bin", bin_cnt, 200);
    do_reset();
    d0 = dut_done;
    send(N, -1, N - 1, 6'h0A, 1'b1, 0);
    check("post_rst_done", dut_done, d0 + 1);
    check("post_rst_ready", frame_ready, 1);
    check("post_rst_exp", frame_exp, 6'h0A);
    drain();

`ifdef FFT_FRAME_SINK_MAG_EN
    do_reset();
    poke_mag = 1'b1;
    send(N, -1, N - 1, 6'h01, 1'b0, 0);
    poke_mag = 1'b0;
    rd_req   = 1'b1;
    rd_addr  = 9'd7;
    step();
    rd_req   = 1'b0;
    check("mag_word", rd_data, 16'h00FF);
    drain();
`endif

    // random frames with random reads and releases
    do_reset();
    for (int f = 0; f < 12; f++) begin
      send(N, -1, N - 1, 6'($urandom), 1'b1, 8);
    end

    // unstructured beats exercise every framing-error path
    for (int k = 0; k < 3000; k++) begin
      src.src_valid = 1'($urandom);
      src.src_sop   = ($urandom_range(0, 63) == 0);
      src.src_eop   = ($urandom_range(0, 63) == 0);
      src.src_real  = DW'($urandom);
      src.src_imag  = DW'($urandom);
      src.src_exp   = 6'($urandom);
      rand_rd(10);
      step();
    end
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
